// File: rtl/serial_pe_unit.sv
// Serial signed multiply-accumulate element: one element pair per valid cycle,
// one registered dot-product result with a single-cycle valid pulse per vector.
module serial_pe_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] neuron,
    input  logic [DATA_W-1:0] weight,
    input  logic [1:0]        ctl,
    input  logic              vld_i,
    output logic [ACC_W-1:0]  result,
    output logic              vld_o
);

    logic signed [2*DATA_W-1:0] prod_full;
    logic        [ACC_W-1:0]    prod_acc;
    logic        [ACC_W-1:0]    sum;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             vld_o_q, vld_o_d;

    // Size cast of a signed value sign-extends when widening and truncates when narrowing.
    always_comb begin
        prod_full = $signed(neuron) * $signed(weight);
        prod_acc  = ACC_W'(prod_full);
    end

    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        vld_o_d  = 1'b0;
        sum      = ctl[0] ? prod_acc : acc_q + prod_acc;
        if (vld_i) begin
            acc_d = sum;
            if (ctl[1]) begin
                result_d = sum;
                vld_o_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            result_q <= '0;
            vld_o_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
            vld_o_q  <= vld_o_d;
        end
    end

    assign result = result_q;
    assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_serial_pe_unit.sv
// Directed bench for serial_pe_unit: per-cycle comparison against a longint
// dot-product model, plus literal expectations for each scenario.
module tb_serial_pe_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] neuron = '0;
    logic [15:0] weight = '0;
    logic [1:0]  ctl = '0;
    logic        vld_i = 1'b0;
    logic [31:0] result;
    logic        vld_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    longint      mdl_sum = 0;
    logic [31:0] exp_res = '0;
    logic        exp_vld = 1'b0;

    int          pulse_cyc[$];
    logic [31:0] pulse_res[$];

    serial_pe_unit #(.DATA_W(16), .ACC_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .neuron(neuron),
        .weight(weight),
        .ctl   (ctl),
        .vld_i (vld_i),
        .result(result),
        .vld_o (vld_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle, advance the model on the sampling edge, compare #1 later.
    task automatic step(input logic r, input logic [15:0] n, input logic [15:0] w,
                        input logic [1:0] c, input logic v);
        longint p;
        rst = r; neuron = n; weight = w; ctl = c; vld_i = v;
        @(posedge clk);
        exp_vld = 1'b0;
        if (r) begin
            mdl_sum = 0;
            exp_res = '0;
        end else if (v) begin
            p = longint'($signed(n)) * longint'($signed(w));
            mdl_sum = c[0] ? p : mdl_sum + p;
            if (c[1]) begin
                exp_res = mdl_sum[31:0];
                exp_vld = 1'b1;
            end
        end
        #1;
        chk("vld_o", {31'b0, vld_o}, {31'b0, exp_vld});
        chk("result", result, exp_res);
        if (vld_o) begin
            pulse_cyc.push_back(cyc);
            pulse_res.push_back(result);
        end
        cyc++;
    endtask

    task automatic run_vec(input logic [15:0] n, input logic [15:0] w, input int len, input int gap_at);
        int np;
        for (int i = 0; i < len; i++) begin
            step(1'b0, n, w, {(i == len - 1), (i == 0)}, 1'b1);
            if (i == gap_at) begin
                np = pulse_res.size();
                for (int g = 0; g < 3; g++)
                    step(1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'b0);
                chk("gap_no_pulse", pulse_res.size(), np);
            end
        end
    endtask

    task automatic expect_last(input string name, input int np0, input logic [31:0] exp);
        int np;
        np = pulse_res.size();
        chk({name, "_pulses"}, np - np0, 1);
        if (np > 0) chk({name, "_res"}, pulse_res[np-1], exp);
    endtask

    initial begin
        int np0;
        step(1'b1, 16'd0, 16'd0, 2'b00, 1'b0);
        step(1'b1, 16'h1234, 16'h5678, 2'b11, 1'b1);
        chk("reset_result", result, 32'h0);
        chk("reset_vld", {31'b0, vld_o}, 32'h0);
        step(1'b0, 16'd0, 16'd0, 2'b00, 1'b0);

        np0 = pulse_res.size();
        run_vec(16'd1, 16'd2, 32, -1);
        expect_last("basic", np0, 32'd64);
        step(1'b0, 16'd0, 16'd0, 2'b00, 1'b0);
        chk("hold_result", result, 32'd64);

        np0 = pulse_res.size();
        run_vec(16'hFFFD, 16'd5, 32, -1);
        expect_last("signed", np0, 32'hFFFFFE20);

        np0 = pulse_res.size();
        run_vec(16'h7FFF, 16'h7FFF, 32, -1);
        expect_last("wrap", np0, 32'hFFE00020);

        np0 = pulse_res.size();
        run_vec(16'd1, 16'd2, 32, 15);
        expect_last("gap", np0, 32'd64);

        np0 = pulse_res.size();
        run_vec(16'd1, 16'd1, 32, -1);
        run_vec(16'd2, 16'd3, 32, -1);
        chk("b2b_pulses", pulse_res.size() - np0, 2);
        if (pulse_res.size() - np0 == 2) begin
            chk("b2b_a", pulse_res[np0], 32'd32);
            chk("b2b_b", pulse_res[np0+1], 32'd192);
            chk("b2b_spacing", pulse_cyc[np0+1] - pulse_cyc[np0], 32);
        end

        np0 = pulse_res.size();
        for (int i = 0; i < 10; i++)
            step(1'b0, 16'd4, 16'd4, {1'b0, (i == 0)}, 1'b1);
        step(1'b1, 16'd4, 16'd4, 2'b10, 1'b1);
        chk("midrst_result", result, 32'h0);
        chk("midrst_vld", {31'b0, vld_o}, 32'h0);
        chk("midrst_no_pulse", pulse_res.size(), np0);

        step(1'b0, 16'hFFF9, 16'd9, 2'b11, 1'b1);
        chk("one_elem_res", result, 32'hFFFFFFC1);
        chk("one_elem_vld", {31'b0, vld_o}, 32'h1);

        // Finish without a start marker: continues the running sum (-63 + 1).
        step(1'b0, 16'd1, 16'd1, 2'b10, 1'b1);
        chk("nostart_res", result, 32'hFFFFFFC2);
        step(1'b0, 16'd0, 16'd0, 2'b00, 1'b0);
        chk("idle_vld", {31'b0, vld_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
